axi_ad7124_frame_sched: RTL and testbench

AXI_AD7124_FRAME_SCHED -- requirements
Module: axi_ad7124_frame_sched

---
 rtl/axi_ad7124_pkg.sv | 20 ++
 rtl/axi_ad7124_frame_sched.sv | 193 +++++++++++++++++++
 tb/tb_axi_ad7124_frame_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_ad7124_pkg.sv
// Shared types and defaults for the AD7124 frame bank scheduler.
package axi_ad7124_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } bank_state_t;

  localparam int DEF_BANK_STRIDE  = 512;
  localparam int DEF_FILL_TIMEOUT = 1023;
  localparam int ADDR_W           = 13;
  localparam int SEQ_W            = 32;
  localparam int ECNT_W           = 16;

  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi_ad7124_frame_sched.sv
// Double-buffer scheduler: hands frame banks to a writer and presents finished
// frames to the host oldest-first, with timeout and drop accounting.
module axi_ad7124_frame_sched
  import axi_ad7124_pkg::*;
#(
  parameter int               BANK_STRIDE  = DEF_BANK_STRIDE,
  parameter int               FILL_TIMEOUT = DEF_FILL_TIMEOUT,
  parameter logic [SEQ_W-1:0] SEQ_RESET    = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic                wr_done,
  output logic                wr_grant,
  output logic                wr_drop,
  output logic [ADDR_W-1:0]   wr_base,
  input  logic                rd_ack,
  output logic                rd_ready,
  output logic [ADDR_W-1:0]   rd_base,
  output logic [SEQ_W-1:0]    rd_seq,
  input  logic                irq_en,
  output logic                irq,
  output logic [ECNT_W-1:0]   drop_cnt,
  output logic [ECNT_W-1:0]   tmo_cnt
);

  localparam int FC_W = $clog2(FILL_TIMEOUT + 1);

  bank_state_t       bank_r [0:1];
  bank_state_t       bank_s [0:1];
  logic [SEQ_W-1:0]  bank_seq_r [0:1];
  logic [SEQ_W-1:0]  bank_seq_s [0:1];
  logic [SEQ_W-1:0]  seq_r, seq_s;
  logic [FC_W-1:0]   fill_cnt_r, fill_cnt_s;
  logic              last_r, last_s;
  logic              oldest_r, oldest_s;
  logic              filling_s, fill_idx_s, restart_s, restart_idx_s;
  logic              grant_s, grant_idx_s, drop_s;
  logic              wr_grant_r, wr_drop_r, rd_ready_r, rd_ready_s, irq_r, irq_s;
  logic [ADDR_W-1:0] wr_base_r, wr_base_s, rd_base_r, rd_base_s;
  logic [SEQ_W-1:0]  rd_seq_r, rd_seq_s;
  logic [ECNT_W-1:0] drop_cnt_r, drop_cnt_s, tmo_cnt_r, tmo_cnt_s;

  function automatic logic [ADDR_W-1:0] bank_base(input logic idx);
    return idx ? ADDR_W'(BANK_STRIDE) : {ADDR_W{1'b0}};
  endfunction

  // Next-state: host ack, then writer completion/timeout, then writer request.
  always_comb begin
    bank_s[0]     = bank_r[0];
    bank_s[1]     = bank_r[1];
    bank_seq_s[0] = bank_seq_r[0];
    bank_seq_s[1] = bank_seq_r[1];
    seq_s         = seq_r;
    last_s        = last_r;
    fill_cnt_s    = fill_cnt_r;
    grant_s       = 1'b0;
    grant_idx_s   = 1'b0;
    drop_s        = 1'b0;
    wr_base_s     = wr_base_r;
    drop_cnt_s    = drop_cnt_r;
    tmo_cnt_s     = tmo_cnt_r;
    oldest_s      = oldest_r;
    rd_base_s     = {ADDR_W{1'b0}};
    rd_seq_s      = {SEQ_W{1'b0}};

    if (rd_ack && rd_ready_r) begin
      bank_s[oldest_r] = FREE;
    end else begin
      bank_s[oldest_r] = bank_r[oldest_r];
    end

    filling_s  = (bank_s[0] == FILL) || (bank_s[1] == FILL);
    fill_idx_s = (bank_s[1] == FILL);
    // Completion wins over a timeout landing on the same edge.
    if (filling_s && wr_done) begin
      bank_s[fill_idx_s] = READY;
    end else if (filling_s && (fill_cnt_r == FC_W'(FILL_TIMEOUT))) begin
      bank_s[fill_idx_s] = FREE;
      tmo_cnt_s          = sat_inc(tmo_cnt_r);
    end else begin
      tmo_cnt_s = tmo_cnt_r;
    end

    restart_s     = (bank_s[0] == FILL) || (bank_s[1] == FILL);
    restart_idx_s = (bank_s[1] == FILL);
    if (wr_req) begin
      if (restart_s) begin
        grant_s     = 1'b1;
        grant_idx_s = restart_idx_s;
        tmo_cnt_s   = sat_inc(tmo_cnt_s);
      end else if ((bank_s[0] == FREE) && (bank_s[1] == FREE)) begin
        grant_s     = 1'b1;
        grant_idx_s = ~last_r;
      end else if (bank_s[0] == FREE) begin
        grant_s     = 1'b1;
        grant_idx_s = 1'b0;
      end else if (bank_s[1] == FREE) begin
        grant_s     = 1'b1;
        grant_idx_s = 1'b1;
      end else begin
        drop_s     = 1'b1;
        drop_cnt_s = sat_inc(drop_cnt_r);
      end
    end else begin
      drop_s = 1'b0;
    end

    if (grant_s) begin
      bank_s[grant_idx_s]     = FILL;
      bank_seq_s[grant_idx_s] = seq_r;
      seq_s                   = seq_r + 32'd1;
      last_s                  = grant_idx_s;
      fill_cnt_s              = {FC_W{1'b0}};
      wr_base_s               = bank_base(grant_idx_s);
    end else if (restart_s) begin
      fill_cnt_s = fill_cnt_r + FC_W'(1);
    end else begin
      fill_cnt_s = {FC_W{1'b0}};
    end

    // Frames complete in sequence order, so the pointer only moves when its bank leaves READY.
    if (bank_s[oldest_r] == READY) begin
      oldest_s = oldest_r;
    end else if (bank_s[~oldest_r] == READY) begin
      oldest_s = ~oldest_r;
    end else begin
      oldest_s = oldest_r;
    end

    rd_ready_s = (bank_s[oldest_s] == READY);
    if (rd_ready_s) begin
      rd_base_s = bank_base(oldest_s);
      rd_seq_s  = bank_seq_s[oldest_s];
    end else begin
      rd_base_s = {ADDR_W{1'b0}};
      rd_seq_s  = {SEQ_W{1'b0}};
    end
    irq_s = rd_ready_s & irq_en;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_r[0]     <= FREE;
      bank_r[1]     <= FREE;
      bank_seq_r[0] <= {SEQ_W{1'b0}};
      bank_seq_r[1] <= {SEQ_W{1'b0}};
      seq_r         <= SEQ_RESET;
      fill_cnt_r    <= {FC_W{1'b0}};
      last_r        <= 1'b1;
      oldest_r      <= 1'b1;
      wr_grant_r    <= 1'b0;
      wr_drop_r     <= 1'b0;
      wr_base_r     <= {ADDR_W{1'b0}};
      rd_ready_r    <= 1'b0;
      rd_base_r     <= {ADDR_W{1'b0}};
      rd_seq_r      <= {SEQ_W{1'b0}};
      irq_r         <= 1'b0;
      drop_cnt_r    <= {ECNT_W{1'b0}};
      tmo_cnt_r     <= {ECNT_W{1'b0}};
    end else begin
      bank_r[0]     <= bank_s[0];
      bank_r[1]     <= bank_s[1];
      bank_seq_r[0] <= bank_seq_s[0];
      bank_seq_r[1] <= bank_seq_s[1];
      seq_r         <= seq_s;
      fill_cnt_r    <= fill_cnt_s;
      last_r        <= last_s;
      oldest_r      <= oldest_s;
      wr_grant_r    <= grant_s;
      wr_drop_r     <= drop_s;
      wr_base_r     <= wr_base_s;
      rd_ready_r    <= rd_ready_s;
      rd_base_r     <= rd_base_s;
      rd_seq_r      <= rd_seq_s;
      irq_r         <= irq_s;
      drop_cnt_r    <= drop_cnt_s;
      tmo_cnt_r     <= tmo_cnt_s;
    end
  end

  assign wr_grant = wr_grant_r;
  assign wr_drop  = wr_drop_r;
  assign wr_base  = wr_base_r;
  assign rd_ready = rd_ready_r;
  assign rd_base  = rd_base_r;
  assign rd_seq   = rd_seq_r;
  assign irq      = irq_r;
  assign drop_cnt = drop_cnt_r;
  assign tmo_cnt  = tmo_cnt_r;

endmodule

// File: tb/tb_axi_ad7124_frame_sched.sv
// Directed bench for the frame scheduler: a per-cycle vector table plus
// hand-written timeout sequences. A second instance starts its sequence at 2^32-1.
module tb_axi_ad7124_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, wr_req = 1'b0, wr_done = 1'b0, rd_ack = 1'b0, irq_en = 1'b0;

  logic        g1, d1, rr1, irq1, g2, d2, rr2, irq2;
  logic [12:0] wb1, rb1, wb2, rb2;
  logic [31:0] rs1, rs2;
  logic [15:0] dc1, tc1, dc2, tc2;

  axi_ad7124_frame_sched u_dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_done(wr_done), .wr_grant(g1), .wr_drop(d1),
    .wr_base(wb1), .rd_ack(rd_ack), .rd_ready(rr1), .rd_base(rb1), .rd_seq(rs1),
    .irq_en(irq_en), .irq(irq1), .drop_cnt(dc1), .tmo_cnt(tc1)
  );

  axi_ad7124_frame_sched #(.SEQ_RESET(32'hFFFF_FFFF)) u_dut_wrap (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_done(wr_done), .wr_grant(g2), .wr_drop(d2),
    .wr_base(wb2), .rd_ack(rd_ack), .rd_ready(rr2), .rd_base(rb2), .rd_seq(rs2),
    .irq_en(irq_en), .irq(irq2), .drop_cnt(dc2), .tmo_cnt(tc2)
  );

  typedef struct {
    logic g; logic d; logic [12:0] wb; logic rr; logic [12:0] rb;
    logic [31:0] rs; logic irq; logic [15:0] dc; logic [15:0] tc;
  } out_t;

  typedef struct {
    logic rst; logic req; logic done; logic ack; logic ien;
    out_t e; logic [31:0] rs_wrap;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".wr_grant"}, 32'(a.g),   32'(e.g));
    chk({tag, ".wr_drop"},  32'(a.d),   32'(e.d));
    chk({tag, ".wr_base"},  32'(a.wb),  32'(e.wb));
    chk({tag, ".rd_ready"}, 32'(a.rr),  32'(e.rr));
    chk({tag, ".rd_base"},  32'(a.rb),  32'(e.rb));
    chk({tag, ".rd_seq"},   a.rs,       e.rs);
    chk({tag, ".irq"},      32'(a.irq), 32'(e.irq));
    chk({tag, ".drop_cnt"}, 32'(a.dc),  32'(e.dc));
    chk({tag, ".tmo_cnt"},  32'(a.tc),  32'(e.tc));
  endtask

  function automatic out_t get1();
    out_t o;
    o = '{g1, d1, wb1, rr1, rb1, rs1, irq1, dc1, tc1};
    return o;
  endfunction

  function automatic out_t get2();
    out_t o;
    o = '{g2, d2, wb2, rr2, rb2, rs2, irq2, dc2, tc2};
    return o;
  endfunction

  function automatic vec_t v(input logic r, q, dn, ak, ie, g, d, input logic [12:0] wb,
                             input logic rr, input logic [12:0] rb, input logic [31:0] rs,
                             input logic ir, input logic [15:0] dc, tc, input logic [31:0] rs_w);
    vec_t x;
    x.rst = r; x.req = q; x.done = dn; x.ack = ak; x.ien = ie;
    x.e = '{g, d, wb, rr, rb, rs, ir, dc, tc};
    x.rs_wrap = rs_w;
    return x;
  endfunction

  task automatic step(input logic r, q, dn, ak, ie);
    rst = r; wr_req = q; wr_done = dn; rd_ack = ak; irq_en = ie;
    @(posedge clk);
    #1;
  endtask

  vec_t vq[$];

  initial begin
    out_t e2;
    //         rst req dn ack ien  g  d   wb      rr  rb      rs     irq dc  tc   rs(wrap instance)
    vq.push_back(v(1, 0, 0, 0, 1,  0, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(1, 0, 0, 0, 1,  0, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(0, 1, 0, 0, 1,  1, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 1,  0, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd0,   1, 13'd0,   32'd0, 1, 16'd0, 16'd0, 32'hFFFF_FFFF));
    vq.push_back(v(0, 1, 0, 0, 1,  1, 0, 13'd512, 1, 13'd0,   32'd0, 1, 16'd0, 16'd0, 32'hFFFF_FFFF));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd512, 1, 13'd0,   32'd0, 1, 16'd0, 16'd0, 32'hFFFF_FFFF));
    vq.push_back(v(0, 1, 0, 0, 1,  0, 1, 13'd512, 1, 13'd0,   32'd0, 1, 16'd1, 16'd0, 32'hFFFF_FFFF));
    vq.push_back(v(0, 0, 0, 0, 1,  0, 0, 13'd512, 1, 13'd0,   32'd0, 1, 16'd1, 16'd0, 32'hFFFF_FFFF));
    vq.push_back(v(0, 0, 0, 1, 1,  0, 0, 13'd512, 1, 13'd512, 32'd1, 1, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(0, 1, 0, 0, 1,  1, 0, 13'd0,   1, 13'd512, 32'd1, 1, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd0,   1, 13'd512, 32'd1, 1, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(0, 1, 0, 1, 1,  1, 0, 13'd512, 1, 13'd0,   32'd2, 1, 16'd1, 16'd0, 32'd1));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd512, 1, 13'd0,   32'd2, 1, 16'd1, 16'd0, 32'd1));
    vq.push_back(v(0, 0, 0, 1, 1,  0, 0, 13'd512, 1, 13'd512, 32'd3, 1, 16'd1, 16'd0, 32'd2));
    vq.push_back(v(0, 0, 0, 1, 1,  0, 0, 13'd512, 0, 13'd0,   32'd0, 0, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(0, 0, 0, 1, 1,  0, 0, 13'd512, 0, 13'd0,   32'd0, 0, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd512, 0, 13'd0,   32'd0, 0, 16'd1, 16'd0, 32'd0));
    vq.push_back(v(1, 0, 0, 0, 1,  0, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(0, 1, 0, 0, 1,  1, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd0, 32'd0));
    vq.push_back(v(0, 1, 0, 0, 1,  1, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd1, 32'd0));
    vq.push_back(v(0, 0, 1, 0, 1,  0, 0, 13'd0,   1, 13'd0,   32'd1, 1, 16'd0, 16'd1, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 13'd0,   1, 13'd0,   32'd1, 0, 16'd0, 16'd1, 32'd0));
    vq.push_back(v(0, 0, 0, 1, 1,  0, 0, 13'd0,   0, 13'd0,   32'd0, 0, 16'd0, 16'd1, 32'd0));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].req, vq[i].done, vq[i].ack, vq[i].ien);
      chk_out($sformatf("vec%0d", i), get1(), vq[i].e);
      e2 = vq[i].e;
      e2.rs = vq[i].rs_wrap;
      chk_out($sformatf("vec%0d_wrap", i), get2(), e2);
    end

    // A bank left in FILL for 1024 cycles goes back to FREE.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("tmo.grant", 32'(g1), 32'd1);
    chk("tmo.base", 32'(wb1), 32'd0);
    for (int i = 0; i < 1023; i++) begin
      step(0, 0, 0, 0, 1);
      chk($sformatf("tmo.ready_c%0d", i), 32'(rr1), 32'd0);
    end
    chk("tmo.cnt_before", 32'(tc1), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("tmo.cnt_after", 32'(tc1), 32'd1);
    chk("tmo.ready", 32'(rr1), 32'd0);
    step(0, 1, 0, 0, 1);
    chk("tmo.regrant", 32'(g1), 32'd1);
    chk("tmo.regrant_base", 32'(wb1), 32'd512);
    chk("tmo.no_drop", 32'(d1), 32'd0);

    // wr_done on the timeout edge completes the frame.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("tmo_done.grant", 32'(g1), 32'd1);
    for (int i = 0; i < 1023; i++) begin
      step(0, 0, 0, 0, 1);
    end
    step(0, 0, 1, 0, 1);
    chk("tmo_done.ready", 32'(rr1), 32'd1);
    chk("tmo_done.base", 32'(rb1), 32'd0);
    chk("tmo_done.seq", rs1, 32'd0);
    chk("tmo_done.tmo_cnt", 32'(tc1), 32'd0);
    chk("tmo_done.irq", 32'(irq1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
